// File: rtl/test_ctrl_pkg.sv
// Shared register map, status bit positions and FSM encoding for the
// Wishbone test controller.
package test_ctrl_pkg;

  localparam logic [4:0] REG_MAILBOX  = 5'h00;
  localparam logic [4:0] REG_CONSOLE  = 5'h04;
  localparam logic [4:0] REG_CYCLE_LO = 5'h08;
  localparam logic [4:0] REG_CYCLE_HI = 5'h0C;
  localparam logic [4:0] REG_TIMEOUT  = 5'h10;
  localparam logic [4:0] REG_STATUS   = 5'h14;

  localparam int unsigned STAT_DONE    = 0;
  localparam int unsigned STAT_PASS    = 1;
  localparam int unsigned STAT_FAIL    = 2;
  localparam int unsigned STAT_TIMEOUT = 3;
  localparam int unsigned STAT_CNT_LSB = 8;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DONE = 1'b1
  } state_t;

  localparam logic [7:0] DEF_PASS_CODE = 8'h01;
  localparam logic [7:0] DEF_FAIL_CODE = 8'hFF;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO with registered full/empty flags.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt_nxt;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_comb begin
    cnt_nxt = count;
    if (do_push && !do_pop) begin
      cnt_nxt = count + CW'(1);
    end else if (do_pop && !do_push) begin
      cnt_nxt = count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= cnt_nxt;
      full  <= (cnt_nxt == CW'(DEPTH));
      empty <= (cnt_nxt == '0);
    end
  end

  // Storage needs no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/wb_test_ctrl.sv
// Wishbone B4 pipelined test controller: pass/fail mailbox, 64-bit cycle
// counter, watchdog and buffered console byte stream.
module wb_test_ctrl
  import test_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned MAX_CYCLES = 200_000,
  parameter logic [7:0]  PASS_CODE  = DEF_PASS_CODE,
  parameter logic [7:0]  FAIL_CODE  = DEF_FAIL_CODE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  input  logic              wb_we_i,
  input  logic [3:0]        wb_sel_i,
  input  logic [ADDR_W-1:0] wb_adr_i,
  input  logic [31:0]       wb_dat_i,
  output logic [31:0]       wb_dat_o,
  output logic              wb_ack_o,
  output logic              wb_stall_o,
  output logic              con_valid_o,
  output logic [7:0]        con_data_o,
  input  logic              con_ready_i,
  output logic              done_o,
  output logic              pass_o,
  output logic              fail_o,
  output logic              timeout_o,
  output logic [7:0]        exit_code_o
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  state_t        state;
  state_t        state_nxt;
  logic [63:0]   cycle_cnt;
  logic [31:0]   timeout_q;
  logic [31:0]   hi_snap;
  logic [31:0]   rd_data;
  logic [4:0]    reg_off;
  logic          accept;
  logic          wr;
  logic          rd;
  logic          mb_wr;
  logic          wd_fire;
  logic          pass_set;
  logic          fail_set;
  logic          to_set;
  logic          cnt_en;
  logic          fifo_push;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          unused_ok;

  assign unused_ok = ^{wb_adr_i[ADDR_W-1:5], wb_adr_i[1:0], wb_sel_i[3:1]};

  assign reg_off    = {wb_adr_i[4:2], 2'b00};
  assign wb_stall_o = fifo_full & wb_cyc_i & wb_stb_i & wb_we_i & (reg_off == REG_CONSOLE);
  assign accept     = wb_cyc_i & wb_stb_i & ~wb_stall_o;
  assign wr         = accept & wb_we_i;
  assign rd         = accept & ~wb_we_i;
  assign mb_wr      = wr & (reg_off == REG_MAILBOX) & wb_sel_i[0] & (state == ST_RUN);
  assign fifo_push  = wr & (reg_off == REG_CONSOLE) & wb_sel_i[0];
  assign wd_fire    = (state == ST_RUN) && (timeout_q != '0) &&
                      (cycle_cnt[63:32] == '0) && (cycle_cnt[31:0] == timeout_q);

  assign done_o      = (state == ST_DONE);
  assign con_valid_o = ~fifo_empty;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_con_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   (wb_dat_i[7:0]),
    .pop   (con_valid_o & con_ready_i),
    .dout  (con_data_o),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Mailbox outranks the watchdog; counter freezes on the ending cycle.
  always_comb begin
    state_nxt = state;
    pass_set  = 1'b0;
    fail_set  = 1'b0;
    to_set    = 1'b0;
    cnt_en    = 1'b0;
    case (state)
      ST_RUN: begin
        if (mb_wr && wb_dat_i[7:0] == PASS_CODE) begin
          state_nxt = ST_DONE;
          pass_set  = 1'b1;
        end else if (mb_wr && wb_dat_i[7:0] == FAIL_CODE) begin
          state_nxt = ST_DONE;
          fail_set  = 1'b1;
        end else if (wd_fire) begin
          state_nxt = ST_DONE;
          to_set    = 1'b1;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_DONE: state_nxt = ST_DONE;
      default: state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    rd_data = '0;
    case (reg_off)
      REG_MAILBOX:  rd_data = {24'b0, exit_code_o};
      REG_CYCLE_LO: rd_data = cycle_cnt[31:0];
      REG_CYCLE_HI: rd_data = hi_snap;
      REG_TIMEOUT:  rd_data = timeout_q;
      REG_STATUS: begin
        rd_data[STAT_DONE]          = done_o;
        rd_data[STAT_PASS]          = pass_o;
        rd_data[STAT_FAIL]          = fail_o;
        rd_data[STAT_TIMEOUT]       = timeout_o;
        rd_data[STAT_CNT_LSB +: 8]  = 8'(fifo_count);
      end
      default: rd_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt   <= '0;
      timeout_q   <= 32'(MAX_CYCLES);
      hi_snap     <= '0;
      exit_code_o <= '0;
      pass_o      <= 1'b0;
      fail_o      <= 1'b0;
      timeout_o   <= 1'b0;
      wb_ack_o    <= 1'b0;
      wb_dat_o    <= '0;
    end else begin
      if (cnt_en) cycle_cnt <= cycle_cnt + 64'd1;
      if (mb_wr) exit_code_o <= wb_dat_i[7:0];
      if (wr && reg_off == REG_TIMEOUT) timeout_q <= wb_dat_i;
      // HI snapshot keeps a LO-then-HI read pair coherent across a carry.
      if (rd && reg_off == REG_CYCLE_LO) hi_snap <= cycle_cnt[63:32];
      pass_o    <= pass_o | pass_set;
      fail_o    <= fail_o | fail_set;
      timeout_o <= timeout_o | to_set;
      wb_ack_o  <= accept;
      wb_dat_o  <= rd ? rd_data : '0;
    end
  end

endmodule
